// File: rtl/bias_fetch_ctrl_pkg.sv
// Shared constants for the bias fetch sequencer: bias word width, ROM size, FSM encodings.
// No logic; no latency; no flow control.
// Imported by every file of the block.
package bias_fetch_ctrl_pkg;

    localparam int CNN_PARA_WIDTH = 16;
    localparam int CNN_BIAS_SIZE  = 32;

    localparam logic [1:0] BF_IDLE  = 2'd0;
    localparam logic [1:0] BF_FETCH = 2'd1;
    localparam logic [1:0] BF_DRAIN = 2'd2;
    localparam logic [1:0] BF_DONE  = 2'd3;

endpackage

// File: rtl/bias_sync_fifo.sv
// Small synchronous FIFO with occupancy count and synchronous flush.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: push into a full FIFO and pop from an empty one are ignored; flush beats both.
module bias_sync_fifo
    import bias_fetch_ctrl_pkg::*;
#(
    parameter int WIDTH = 21,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    always_comb begin
        empty   = (count == CW'(0));
        full    = (count == CW'(DEPTH));
        push_ok = push && !full;
        pop_ok  = pop && !empty;
    end

    assign head_data = mem[rd_ptr];

    // Storage is reset too so the head reads zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bias_fetch_ctrl.sv
// Bias ROM sequencer: reads ch_num consecutive words from base_addr and streams them with channel index.
// Latency: start edge -> rom_r_en next cycle -> bias_valid two edges later; one bias per cycle when ready.
// Backpressure: reads issue only while FIFO occupancy plus in-flight reads stays below FIFO_DEPTH.
module bias_fetch_ctrl
    import bias_fetch_ctrl_pkg::*;
#(
    parameter int DATA_W     = CNN_PARA_WIDTH,
    parameter int ADDR_W     = $clog2(CNN_BIAS_SIZE),
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   ch_num,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              rom_r_en,
    output logic [ADDR_W-1:0] rom_raddr,
    input  logic [DATA_W-1:0] rom_dout,
    output logic              bias_valid,
    input  logic              bias_ready,
    output logic [DATA_W-1:0] bias_data,
    output logic [ADDR_W-1:0] bias_idx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W:0] CH_MAX = {1'b1, {ADDR_W{1'b0}}};

    logic [1:0]        state;
    logic              rd_pend;
    logic [ADDR_W:0]   reads_left;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] wr_idx;

    logic [ADDR_W:0]   ch_eff;
    logic              abort_act;
    logic [CW:0]       occ;
    logic              issue;
    logic              push;
    logic              pop;
    logic              drain_empty;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;

    always_comb begin
        ch_eff      = (ch_num > CH_MAX) ? CH_MAX : ch_num;
        abort_act   = abort && (state != BF_IDLE);
        // rom_r_en and rd_pend are the (at most two) reads whose data is not yet in the FIFO.
        occ         = (CW+1)'(fifo_count) + (CW+1)'(rom_r_en) + (CW+1)'(rd_pend);
        issue       = (state == BF_FETCH) && (reads_left != '0)
                      && (occ < (CW+1)'(FIFO_DEPTH)) && !abort_act;
        push        = rd_pend && !abort_act;
        pop         = bias_valid && bias_ready && !abort_act;
        drain_empty = !rom_r_en && !rd_pend
                      && ((fifo_count == CW'(0)) || ((fifo_count == CW'(1)) && pop));
        bias_valid  = !fifo_empty;
        busy        = (state == BF_FETCH) || (state == BF_DRAIN);
        done        = (state == BF_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BF_IDLE;
            rom_r_en   <= 1'b0;
            rom_raddr  <= '0;
            rd_pend    <= 1'b0;
            reads_left <= '0;
            next_addr  <= '0;
            wr_idx     <= '0;
        end else begin
            rd_pend <= rom_r_en && !abort_act;
            if (push) begin
                wr_idx <= wr_idx + ADDR_W'(1);
            end
            case (state)
                BF_IDLE: begin
                    rom_r_en <= 1'b0;
                    if (start) begin
                        wr_idx <= '0;
                        if (ch_eff == '0) begin
                            state <= BF_DONE;
                        end else begin
                            // First read goes out straight from IDLE to meet the one-cycle start latency.
                            rom_r_en   <= 1'b1;
                            rom_raddr  <= base_addr;
                            next_addr  <= base_addr + ADDR_W'(1);
                            reads_left <= ch_eff - (ADDR_W+1)'(1);
                            state      <= (ch_eff == (ADDR_W+1)'(1)) ? BF_DRAIN : BF_FETCH;
                        end
                    end
                end
                BF_FETCH: begin
                    rom_r_en <= issue;
                    if (abort_act) begin
                        state <= BF_DONE;
                    end else if (issue) begin
                        rom_raddr  <= next_addr;
                        next_addr  <= next_addr + ADDR_W'(1);
                        reads_left <= reads_left - (ADDR_W+1)'(1);
                        if (reads_left == (ADDR_W+1)'(1)) begin
                            state <= BF_DRAIN;
                        end
                    end
                end
                BF_DRAIN: begin
                    rom_r_en <= 1'b0;
                    if (abort_act || drain_empty) begin
                        state <= BF_DONE;
                    end
                end
                default: begin
                    rom_r_en <= 1'b0;
                    state    <= BF_IDLE;
                end
            endcase
        end
    end

    bias_sync_fifo #(
        .WIDTH (DATA_W + ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (abort_act),
        .push      (push),
        .push_data ({wr_idx, rom_dout}),
        .pop       (pop),
        .head_data ({bias_idx, bias_data}),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_bias_fetch_ctrl.sv
// Scoreboarded bench for bias_fetch_ctrl against a bias ROM model holding 16'h0100+addr.
module tb_bias_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  base_addr;
    logic [5:0]  ch_num;
    logic        abort;
    logic        busy;
    logic        done;
    logic        rom_r_en;
    logic [4:0]  rom_raddr;
    logic [15:0] rom_dout;
    logic        bias_valid;
    logic        bias_ready;
    logic [15:0] bias_data;
    logic [4:0]  bias_idx;

    typedef struct packed {
        logic [4:0]  idx;
        logic [15:0] data;
    } exp_t;

    exp_t       sb_q[$];
    logic [4:0] addr_log[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int run_xfer = 0;
    int first_xfer_cyc = 0;
    int last_xfer_cyc = 0;

    bias_fetch_ctrl #(
        .DATA_W     (16),
        .ADDR_W     (5),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .ch_num     (ch_num),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .rom_r_en   (rom_r_en),
        .rom_raddr  (rom_raddr),
        .rom_dout   (rom_dout),
        .bias_valid (bias_valid),
        .bias_ready (bias_ready),
        .bias_data  (bias_data),
        .bias_idx   (bias_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // ROM model: synchronous read, zero when not enabled.
    always @(posedge clk) begin
        if (rom_r_en) rom_dout <= 16'h0100 + {11'd0, rom_raddr};
        else          rom_dout <= 16'h0000;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int base, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.idx  = 5'(k);
            e.data = 16'h0100 + 16'((base + k) & 31);
            sb_q.push_back(e);
        end
    endtask

    // Monitor: samples on the falling edge, handshake excludes abort cycles.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rom_r_en) begin
                rd_cnt++;
                addr_log.push_back(rom_raddr);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bias_valid && bias_ready && !abort) begin
                if (run_xfer == 0) first_xfer_cyc = cyc;
                last_xfer_cyc = cyc;
                run_xfer++;
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_xfer: got idx %0d data %0h, expected no transfer", bias_idx, bias_data);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("xfer_data", 32'(bias_data), 32'(e.data));
                    check("xfer_idx", 32'(bias_idx), 32'(e.idx));
                end
            end
        end
    end

    task automatic run_start(input logic [4:0] base, input logic [5:0] n);
        @(posedge clk);
        #1;
        base_addr = base;
        ch_num    = n;
        start     = 1'b1;
        run_xfer  = 0;
        @(posedge clk);
        #1;
        start     = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check({name, "_done_seen"}, 32'(got), 32'd1);
        check({name, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_xfers(input string name, input int n, input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (run_xfer >= n) begin
                got = 1'b1;
                break;
            end
        end
        check({name, "_xfers_seen"}, 32'(got), 32'd1);
    endtask

    logic [4:0] exp_addr [4];

    initial begin
        exp_addr[0] = 5'd30; exp_addr[1] = 5'd31; exp_addr[2] = 5'd0; exp_addr[3] = 5'd1;
        rst_n = 1'b0; start = 1'b0; base_addr = '0; ch_num = '0; abort = 1'b0; bias_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ctrl", {28'd0, busy, done, rom_r_en, bias_valid}, 32'd0);
        check("rst_raddr", 32'(rom_raddr), 32'd0);
        check("rst_data", 32'(bias_data), 32'd0);
        check("rst_idx", 32'(bias_idx), 32'd0);
        rst_n = 1'b1;

        // Base 0, four words, ready held high.
        bias_ready = 1'b1; rd_cnt = 0; done_cnt = 0;
        push_exp(0, 4);
        run_start(5'd0, 6'd4);
        check("t1_first_ren", 32'(rom_r_en), 32'd1);
        check("t1_first_addr", 32'(rom_raddr), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        wait_done("t1", 40);
        check("t1_rd_cnt", rd_cnt, 4);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_first_valid_lat", first_xfer_cyc - start_cyc, 2);
        check("t1_back_to_back", last_xfer_cyc - first_xfer_cyc, 3);
        check("t1_done_after_last", done_cyc - last_xfer_cyc, 1);
        check("t1_idle_busy", 32'(busy), 32'd0);

        // Address wrap from 30.
        addr_log.delete();
        push_exp(30, 4);
        run_start(5'd30, 6'd4);
        wait_done("t2", 40);
        check("t2_n_reads", 32'(addr_log.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < addr_log.size()) check("t2_addr", 32'(addr_log[k]), 32'(exp_addr[k]));
        end

        // Backpressure: ready low for 8 cycles after first valid.
        bias_ready = 1'b0; rd_cnt = 0; done_cnt = 0;
        push_exp(3, 10);
        run_start(5'd3, 6'd10);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (bias_valid) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("t3_valid_seen", 32'(seen), 32'd1);
        end
        repeat (8) @(posedge clk);
        #1;
        check("t3_reads_capped", 32'(rd_cnt <= 4), 32'd1);
        check("t3_valid_held", 32'(bias_valid), 32'd1);
        bias_ready = 1'b1;
        wait_done("t3", 60);
        check("t3_rd_cnt", rd_cnt, 10);
        check("t3_done_cnt", done_cnt, 1);

        // ch_num 0: immediate done, no reads.
        rd_cnt = 0; done_cnt = 0;
        run_start(5'd9, 6'd0);
        check("t4_zero_done", 32'(done), 32'd1);
        check("t4_zero_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check("t4_zero_done_off", 32'(done), 32'd0);
        check("t4_zero_reads", rd_cnt, 0);

        // Second start while busy is ignored.
        rd_cnt = 0; done_cnt = 0;
        push_exp(5, 4);
        run_start(5'd5, 6'd4);
        base_addr = 5'd20; ch_num = 6'd2; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("t4b", 40);
        repeat (5) @(posedge clk);
        #1;
        check("t4b_done_cnt", done_cnt, 1);
        check("t4b_rd_cnt", rd_cnt, 4);

        // Abort after two transfers, then a clean restart.
        done_cnt = 0;
        push_exp(0, 2);
        run_start(5'd0, 6'd8);
        wait_xfers("t5", 2, 20);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("t5_valid_off", 32'(bias_valid), 32'd0);
        check("t5_ren_off", 32'(rom_r_en), 32'd0);
        check("t5_done", 32'(done), 32'd1);
        @(posedge clk);
        #1;
        check("t5_done_pulse", 32'(done), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("t5_done_cnt", done_cnt, 1);
        check("t5_sb_empty", 32'(sb_q.size()), 32'd0);
        push_exp(0, 3);
        run_start(5'd0, 6'd3);
        wait_done("t5r", 40);

        // Asynchronous reset mid-run, then restart.
        push_exp(0, 8);
        run_start(5'd0, 6'd8);
        wait_xfers("t6", 2, 20);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_rst_ctrl", {28'd0, busy, done, rom_r_en, bias_valid}, 32'd0);
        check("t6_rst_raddr", 32'(rom_raddr), 32'd0);
        check("t6_rst_data", 32'(bias_data), 32'd0);
        check("t6_rst_idx", 32'(bias_idx), 32'd0);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_exp(7, 2);
        run_start(5'd7, 6'd2);
        wait_done("t6r", 40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
